encdec_apb_job_driver: RTL and testbench

- APB requester that programs the EncDec register block and collects its result. It is the initiator side of the CTRL/DATA_IN/CODEWORD_WIDTH/NOISE register interface.
- It accepts one job per valid/ready handshake and performs four APB writes, CTRL last.
- It then waits for operation_done, captures data_out and num_of_errors, and returns them on a result handshake.
- It is used as the stimulus engine in the EncDec testbench and as the bus front-end in system integration.

---
 rtl/encdec_pkg.sv | 25 ++
 rtl/encdec_apb_write_port.sv | 60 ++++++
 rtl/encdec_apb_job_driver.sv | 185 ++++++++++++++++++
 tb/tb_encdec_apb_job_driver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encdec_pkg.sv
// Shared types and constants for the EncDec APB job driver: FSM states,
// register offsets, CTRL encodings and the order in which a job is written.
package encdec_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_e;

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} port_ph_e;

  localparam logic [3:0] CTRL_OFF    = 4'h0;
  localparam logic [3:0] DATA_IN_OFF = 4'h4;
  localparam logic [3:0] CWW_OFF     = 4'h8;
  localparam logic [3:0] NOISE_OFF   = 4'hC;

  localparam logic [1:0] ENC  = 2'b00;
  localparam logic [1:0] DEC  = 2'b01;
  localparam logic [1:0] FULL = 2'b10;

  // Entry 0 is written first; CTRL is last because writing it starts the DUT.
  localparam logic [3:0][3:0] WR_ORDER = {CTRL_OFF, NOISE_OFF, CWW_OFF, DATA_IN_OFF};

  function automatic logic [3:0] wr_offset(input logic [1:0] idx);
    return WR_ORDER[idx];
  endfunction

endpackage

// File: rtl/encdec_apb_write_port.sv
// Single-write APB requester: one SETUP cycle, then ACCESS until pready.
// A start in the completing ACCESS cycle chains straight into the next SETUP.
module encdec_apb_write_port
  import encdec_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready
);

  port_ph_e ph_q, ph_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q   <= PH_IDLE;
      paddr  <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      pwrite <= 1'b1;
      if (start) begin
        paddr  <= addr;
        pwdata <= data;
      end
    end
  end

  always_comb begin
    ph_d = ph_q;
    done = 1'b0;
    case (ph_q)
      PH_IDLE:   if (start) ph_d = PH_SETUP;
      PH_SETUP:  ph_d = PH_ACCESS;
      PH_ACCESS: begin
        if (pready) begin
          done = 1'b1;
          ph_d = start ? PH_SETUP : PH_IDLE;
        end
      end
      default:   ph_d = PH_IDLE;
    endcase
  end

  assign psel    = (ph_q != PH_IDLE);
  assign penable = (ph_q == PH_ACCESS);

endmodule

// File: rtl/encdec_apb_job_driver.sv
// Job-level sequencer: writes DATA_IN, CODEWORD_WIDTH, NOISE, CTRL over APB,
// waits (bounded) for operation_done and hands back the captured result.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | ready for a job; accept latches it and launches the first write
// SETUP     | APB setup phase of write idx_q
// ACCESS    | APB access phase of write idx_q, waiting for pready
// WAIT_DONE | CTRL written, timer running until operation_done or timeout
// RESP      | result held on res_* until res_ready
module encdec_apb_job_driver
  import encdec_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [1:0]                 job_ctrl,
  input  logic [AMBA_WORD-1:0]       job_data_in,
  input  logic [1:0]                 job_width,
  input  logic [AMBA_WORD-1:0]       job_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] paddr,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [AMBA_WORD-1:0]       pwdata,
  input  logic                       pready,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_WIDTH-1:0]      res_data_out,
  output logic [1:0]                 res_num_of_errors,
  output logic                       res_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [1:0]           ctrl_q, width_q;
  logic [AMBA_WORD-1:0] data_in_q, noise_q;

  logic                       latch, wr_start, wr_done, cap_done, cap_to;
  logic [1:0]                 sel_idx, src_ctrl, src_width;
  logic [AMBA_WORD-1:0]       src_data_in, src_noise, wr_data;
  logic [AMBA_ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]                 wr_off;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tmr_q     <= '0;
      ctrl_q    <= '0;
      width_q   <= '0;
      data_in_q <= '0;
      noise_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      if (latch) begin
        ctrl_q    <= job_ctrl;
        width_q   <= job_width;
        data_in_q <= job_data_in;
        noise_q   <= job_noise;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_out      <= '0;
      res_num_of_errors <= '0;
      res_timeout       <= 1'b0;
    end else if (cap_done) begin
      res_data_out      <= data_out;
      res_num_of_errors <= num_of_errors;
      res_timeout       <= 1'b0;
    end else if (cap_to) begin
      res_data_out      <= '0;
      res_num_of_errors <= '0;
      res_timeout       <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_d    = tmr_q;
    latch    = 1'b0;
    wr_start = 1'b0;
    cap_done = 1'b0;
    cap_to   = 1'b0;
    case (state_q)
      IDLE: begin
        if (job_valid) begin
          latch    = 1'b1;
          wr_start = 1'b1;
          idx_d    = 2'd0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (wr_done) begin
          if (idx_q != 2'd3) begin
            idx_d    = idx_q + 2'd1;
            wr_start = 1'b1;
            state_d  = SETUP;
          end else if (operation_done) begin
            // DUT may finish in the very cycle the CTRL write completes
            cap_done = 1'b1;
            state_d  = RESP;
          end else begin
            tmr_d   = TW'(TIMEOUT_CYCLES - 1);
            state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (operation_done) begin
          cap_done = 1'b1;
          state_d  = RESP;
        end else if (tmr_q == '0) begin
          cap_to  = 1'b1;
          state_d = RESP;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      RESP: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/data of the write being launched: the incoming job on accept,
  // otherwise the latched job at the following index.
  always_comb begin
    sel_idx     = (state_q == IDLE) ? 2'd0 : idx_q + 2'd1;
    src_ctrl    = (state_q == IDLE) ? job_ctrl    : ctrl_q;
    src_width   = (state_q == IDLE) ? job_width   : width_q;
    src_data_in = (state_q == IDLE) ? job_data_in : data_in_q;
    src_noise   = (state_q == IDLE) ? job_noise   : noise_q;
    wr_off      = wr_offset(sel_idx);
    wr_addr     = {{(AMBA_ADDR_WIDTH-4){1'b0}}, wr_off};
    case (wr_off)
      CTRL_OFF:    wr_data = {{(AMBA_WORD-2){1'b0}}, src_ctrl};
      DATA_IN_OFF: wr_data = src_data_in;
      CWW_OFF:     wr_data = {{(AMBA_WORD-2){1'b0}}, src_width};
      NOISE_OFF:   wr_data = src_noise;
      default:     wr_data = '0;
    endcase
  end

  encdec_apb_write_port #(
    .ADDR_WIDTH (AMBA_ADDR_WIDTH),
    .DATA_WIDTH (AMBA_WORD)
  ) u_write_port (
    .clk     (clk),
    .rst     (rst),
    .start   (wr_start),
    .addr    (wr_addr),
    .data    (wr_data),
    .done    (wr_done),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pready  (pready)
  );

  assign job_ready = (state_q == IDLE);
  assign res_valid = (state_q == RESP);

endmodule

// File: tb/tb_encdec_apb_job_driver.sv
// Bench for the EncDec APB job driver: a job list (directed + random) is run
// against an APB slave / DUT model kept here, with cycle-accurate expectations.
module tb_encdec_apb_job_driver;

  localparam int DW = 32;
  localparam int AW = 20;
  localparam int WD = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid, job_ready;
  logic [1:0]    job_ctrl, job_width;
  logic [WD-1:0] job_data_in, job_noise;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite, pready;
  logic [WD-1:0] pwdata;
  logic          operation_done;
  logic [DW-1:0] data_out, res_data_out;
  logic [1:0]    num_of_errors, res_num_of_errors;
  logic          res_valid, res_ready, res_timeout;

  always #5 clk = ~clk;

  encdec_apb_job_driver #(
    .DATA_WIDTH      (DW),
    .AMBA_ADDR_WIDTH (AW),
    .AMBA_WORD       (WD),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_ctrl          (job_ctrl),
    .job_data_in       (job_data_in),
    .job_width         (job_width),
    .job_noise         (job_noise),
    .paddr             (paddr),
    .psel              (psel),
    .penable           (penable),
    .pwrite            (pwrite),
    .pwdata            (pwdata),
    .pready            (pready),
    .operation_done    (operation_done),
    .data_out          (data_out),
    .num_of_errors     (num_of_errors),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_data_out      (res_data_out),
    .res_num_of_errors (res_num_of_errors),
    .res_timeout       (res_timeout)
  );

  typedef struct packed {
    logic [1:0]       ctrl;
    logic [31:0]      din;
    logic [1:0]       width;
    logic [31:0]      noise;
    logic [31:0]      dout;
    logic [1:0]       errs;
    int               d;        // done delay in cycles after the CTRL-completing cycle
    logic [3:0][3:0]  wt;       // pready wait states per write, in write order
    int               rr_hold;  // cycles res_ready stays low once res_valid is up
    int               gap;      // idle cycles before job_valid is presented
  } job_t;

  job_t jobs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic job_t mk_job(input logic [1:0] ctrl, input logic [31:0] din,
                                  input logic [1:0] w, input logic [31:0] noise,
                                  input logic [31:0] dout, input logic [1:0] e,
                                  input int d, input logic [15:0] wt,
                                  input int rr, input int gap);
    job_t j;
    j.ctrl = ctrl; j.din = din; j.width = w; j.noise = noise;
    j.dout = dout; j.errs = e; j.d = d; j.wt = wt; j.rr_hold = rr; j.gap = gap;
    return j;
  endfunction

  function automatic job_t rnd_job();
    logic [15:0] wt;
    for (int i = 0; i < 4; i++)
      wt[i*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 4)) : 4'd0;
    return mk_job(2'($urandom_range(0, 2)), $urandom, 2'($urandom), $urandom,
                  $urandom, 2'($urandom),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(17, 30)) : int'($urandom_range(0, 16)),
                  wt, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
  endfunction

  // Register map and write order seen from the bus
  function automatic logic [63:0] exp_addr(input int n);
    case (n)
      0: return 64'h4;
      1: return 64'h8;
      2: return 64'hC;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] exp_data(input job_t j, input int n);
    case (n)
      0: return 64'(j.din);
      1: return 64'(j.width);
      2: return 64'(j.noise);
      default: return 64'(j.ctrl);
    endcase
  endfunction

  task automatic run_jobs();
    int   src = 0, done_n = 0, cyc = 0, gap_left;
    int   wr_n = 0, aph = 0, wleft = 0;   // aph: 0 no transfer, 1 setup, 2 access
    int   ph = 0, wcyc = 0, exp_lat = 0, rr_left = 0;  // ph: 0 busy/idle, 1 waiting, 2 result
    bit   busy = 0, exp_to = 0, completing, accept, handshake;
    job_t cj = '0;
    gap_left = jobs[0].gap;
    job_valid = 1'b0;
    while (done_n < jobs.size() && cyc < 20000) begin
      check("psel", 64'(psel), 64'(aph != 0));
      check("penable", 64'(penable), 64'(aph == 2));
      if (aph != 0) begin
        check("paddr", 64'(paddr), exp_addr(wr_n));
        check("pwdata", 64'(pwdata), exp_data(cj, wr_n));
        check("pwrite", 64'(pwrite), 64'd1);
      end
      if (ph == 1) begin
        wcyc++;
        if (wcyc == exp_lat) begin
          ph = 2;
          rr_left = cj.rr_hold;
        end
      end
      check("res_valid", 64'(res_valid), 64'(ph == 2));
      if (ph == 2) begin
        check("res_data_out", 64'(res_data_out), exp_to ? 64'd0 : 64'(cj.dout));
        check("res_num_of_errors", 64'(res_num_of_errors), exp_to ? 64'd0 : 64'(cj.errs));
        check("res_timeout", 64'(res_timeout), 64'(exp_to));
      end
      check("job_ready", 64'(job_ready), 64'(!busy));

      completing = 0;
      pready = 1'($urandom);
      if (aph == 1) begin
        wleft = int'(cj.wt[wr_n]);
      end else if (aph == 2) begin
        if (wleft > 0) begin
          pready = 1'b0;
          wleft--;
        end else begin
          pready = 1'b1;
          completing = 1;
        end
      end

      operation_done = 1'b0;
      data_out = $urandom;
      num_of_errors = 2'($urandom);
      if (completing && wr_n == 3) begin
        ph = 1;
        wcyc = 0;
        exp_to = (cj.d > TO);
        exp_lat = exp_to ? TO + 1 : cj.d + 1;
      end
      if (ph == 1) begin
        if (wcyc == cj.d) begin
          operation_done = 1'b1;
          data_out = cj.dout;
          num_of_errors = cj.errs;
        end
      end else if ($urandom_range(0, 5) == 0) begin
        operation_done = 1'b1;
      end

      handshake = 0;
      res_ready = 1'($urandom);
      if (ph == 2) begin
        if (rr_left > 0) begin
          res_ready = 1'b0;
          rr_left--;
        end else begin
          res_ready = 1'b1;
          handshake = 1;
        end
      end

      if (!job_valid && src < jobs.size()) begin
        if (gap_left > 0) gap_left--;
        else begin
          job_valid   = 1'b1;
          job_ctrl    = jobs[src].ctrl;
          job_data_in = jobs[src].din;
          job_width   = jobs[src].width;
          job_noise   = jobs[src].noise;
        end
      end
      if (!job_valid) begin
        job_ctrl    = 2'($urandom);
        job_data_in = $urandom;
        job_width   = 2'($urandom);
        job_noise   = $urandom;
      end
      accept = job_valid && !busy;

      if (aph == 1) aph = 2;
      else if (aph == 2 && completing) begin
        if (wr_n < 3) begin
          wr_n++;
          aph = 1;
        end else aph = 0;
      end
      if (handshake) begin
        busy = 0;
        ph = 0;
        done_n++;
      end
      if (accept) begin
        busy = 1;
        cj = jobs[src];
        src++;
        wr_n = 0;
        aph = 1;
        if (src < jobs.size()) gap_left = jobs[src].gap;
      end
      step();
      if (accept) job_valid = 1'b0;
      cyc++;
    end
    check("jobs_completed", 64'(done_n), 64'(jobs.size()));
  endtask

  initial begin
    rst = 1'b1;
    job_valid = 1'b0; job_ctrl = '0; job_data_in = '0; job_width = '0; job_noise = '0;
    pready = 1'b0; operation_done = 1'b0; data_out = '0; num_of_errors = '0; res_ready = 1'b0;
    repeat (3) step();
    check("rst_job_ready", 64'(job_ready), 64'd1);
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_pwrite", 64'(pwrite), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data_out), 64'd0);
    check("rst_res_errs", 64'(res_num_of_errors), 64'd0);
    check("rst_res_timeout", 64'(res_timeout), 64'd0);
    rst = 1'b0;

    // Abort during the DATA_IN access
    job_valid = 1'b1; job_ctrl = 2'b01; job_data_in = 32'h1234; job_width = 2'd2; job_noise = 32'h5;
    step();
    job_valid = 1'b0;
    check("abort_setup", 64'({psel, penable}), 64'b10);
    step();
    check("abort_access", 64'({psel, penable}), 64'b11);
    check("abort_paddr", 64'(paddr), 64'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_psel", 64'(psel), 64'd0);
    check("abort_penable", 64'(penable), 64'd0);
    check("abort_job_ready", 64'(job_ready), 64'd1);
    check("abort_res_valid", 64'(res_valid), 64'd0);

    jobs.push_back(mk_job(2'b00, 32'hA5, 2'd0, 32'h0, 32'hA5, 2'b00, 5, 16'h0000, 0, 0));
    jobs.push_back(mk_job(2'b01, 32'hDEAD_BEEF, 2'd3, 32'h8000_0001, 32'h1357, 2'b01, 3, 16'h0300, 0, 2));
    jobs.push_back(mk_job(2'b10, 32'h0F0F_0F0F, 2'd1, 32'h3, 32'h0, 2'b10, 2, 16'h0000, 0, 1));
    jobs.push_back(mk_job(2'b10, 32'h55AA, 2'd2, 32'h7, 32'hFFFF_FFFF, 2'b11, 40, 16'h0000, 0, 0));
    jobs.push_back(mk_job(2'b00, 32'h1111, 2'd1, 32'h0, 32'h2222, 2'b01, 1, 16'h0000, 10, 0));
    jobs.push_back(mk_job(2'b01, 32'h3333, 2'd2, 32'h1, 32'h4444, 2'b10, 0, 16'h1000, 0, 0));
    jobs.push_back(mk_job(2'b10, 32'h5555, 2'd3, 32'h2, 32'h6666, 2'b11, 16, 16'h0000, 2, 1));
    jobs.push_back(mk_job(2'b00, 32'h7777, 2'd0, 32'h4, 32'h8888, 2'b01, 17, 16'h0000, 0, 0));
    for (int i = 0; i < 40; i++) jobs.push_back(rnd_job());
    run_jobs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
